// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: drives the word address to instruction memory, captures
// the returned word one cycle later and buffers {instr, pc} for decode (valid/ready).
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_busy,
  output logic [31:0]       fetch_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, r_tag_pc;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_fetch_count;

  logic                w_fetch, w_flush, w_pop, w_push, w_issue;
  logic [OCC_W-1:0]    w_occ;

  assign w_fetch = (r_state == FETCH);
  assign w_flush = w_fetch & (redirect_valid | stop);
  assign w_pop   = instr_valid & instr_ready;
  assign w_push  = r_inflight & ~w_flush;
  // Occupancy counts the word still in flight so a full FIFO can never be overrun.
  assign w_occ   = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue = w_fetch & ~redirect_valid & ~stop & (w_occ < OCC_W'(FIFO_DEPTH));

  assign addra       = r_pc;
  assign instr       = r_fifo_data[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];
  assign instr_valid = (r_count != '0);
  assign fetch_busy  = w_fetch;
  assign fetch_count = r_fetch_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = FETCH;
      FETCH:   if (stop)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_tag_pc      <= '0;
      r_inflight    <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else begin
      if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;

      // stop outranks redirect: a flush by stop leaves pc where it was.
      if (!w_fetch && start)                  r_pc <= RESET_PC;
      else if (w_fetch && !stop && redirect_valid) r_pc <= redirect_pc;
      else if (w_issue)                       r_pc <= r_pc + ADDR_W'(1);

      r_inflight <= w_issue;
      if (w_issue) r_tag_pc <= r_pc;

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= douta;
        r_fifo_pc[r_wr_ptr]   <= r_tag_pc;
      end

      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 32-bit-address DUT plus a 4-bit-address twin for PC wrap.
module tb_instr_fetch_unit;
  logic        clka = 1'b0;
  logic        rst_n;
  logic        start, stop, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [31:0] addra, douta, instr, instr_pc, fetch_count;
  logic        instr_valid, fetch_busy;

  logic [3:0]  redirect_pc4, addra4, instr_pc4;
  logic [31:0] douta4, instr4, fetch_count4;
  logic        instr_valid4, fetch_busy4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clka = ~clka;

  // Memory model: word k holds 0x100+k, read latency one cycle.
  always @(posedge clka) begin
    douta  <= 32'h100 + addra;
    douta4 <= 32'h100 + {28'h0, addra4};
  end

  assign redirect_pc4 = redirect_pc[3:0];

  instr_fetch_unit u_dut (
    .clka(clka), .rst_n(rst_n), .start(start), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .addra(addra), .douta(douta), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_busy(fetch_busy), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.ADDR_W(4)) u_dut4 (
    .clka(clka), .rst_n(rst_n), .start(start), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc4),
    .addra(addra4), .douta(douta4), .instr(instr4), .instr_pc(instr_pc4),
    .instr_valid(instr_valid4), .instr_ready(instr_ready),
    .fetch_busy(fetch_busy4), .fetch_count(fetch_count4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_addra", addra, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_valid4", instr_valid4, 0);
    rst_n = 1'b1;
    tick();

    // Start and stream
    instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("st0_busy", fetch_busy, 1);
    chk("st0_valid", instr_valid, 0);
    chk("st0_addra", addra, 0);
    tick();
    chk("st1_valid", instr_valid, 0);
    chk("st1_addra", addra, 1);
    tick();
    chk("st2_valid", instr_valid, 1);
    chk("st2_pc", instr_pc, 0);
    chk("st2_instr", instr, 32'h100);
    chk("st2_count", fetch_count, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, k);
      chk("stream_instr", instr, 32'h100 + k);
      chk("stream_count", fetch_count, k);
    end

    // Backpressure: head pc3 held, pc4 lands, fetch stalls at 5
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("bp_valid", instr_valid, 1);
    chk("bp_pc", instr_pc, 3);
    chk("bp_instr", instr, 32'h103);
    chk("bp_addra", addra, 5);
    chk("bp_count", fetch_count, 3);
    instr_ready = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      tick();
      chk("rel_valid", instr_valid, 1);
      chk("rel_pc", instr_pc, k);
      chk("rel_instr", instr, 32'h100 + k);
      chk("rel_count", fetch_count, k);
    end

    // Redirect near the top of the address space (wrap), twin goes to 0xE
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("rd0_valid", instr_valid, 0);
    chk("rd0_addra", addra, 32'hFFFF_FFFE);
    chk("rd0_count", fetch_count, 7);
    tick();
    chk("rd1_valid", instr_valid, 0);
    chk("rd1_addra", addra, 32'hFFFF_FFFF);
    tick();
    chk("rd2_valid", instr_valid, 1);
    chk("rd2_pc", instr_pc, 32'hFFFF_FFFE);
    chk("rd2_instr", instr, 32'hFE);
    chk("rd2_pc4", instr_pc4, 4'hE);
    chk("rd2_instr4", instr4, 32'h10E);
    tick();
    chk("rd3_pc", instr_pc, 32'hFFFF_FFFF);
    chk("rd3_instr", instr, 32'hFF);
    chk("rd3_pc4", instr_pc4, 4'hF);
    chk("rd3_instr4", instr4, 32'h10F);
    tick();
    chk("rd4_pc", instr_pc, 0);
    chk("rd4_pc4", instr_pc4, 4'h0);
    chk("rd4_instr4", instr4, 32'h100);
    tick();
    chk("rd5_pc", instr_pc, 1);
    chk("rd5_instr", instr, 32'h101);
    chk("rd5_pc4", instr_pc4, 4'h1);
    chk("rd5_count", fetch_count, 10);

    // Stop during streaming; redirect in IDLE is ignored
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_valid", instr_valid, 0);
    chk("stop_busy", fetch_busy, 0);
    chk("stop_addra", addra, 3);
    chk("stop_count", fetch_count, 11);
    redirect_valid = 1'b1; redirect_pc = 32'h55; tick(); redirect_valid = 1'b0;
    chk("idle_rd_addra", addra, 3);
    chk("idle_rd_valid", instr_valid, 0);
    tick();
    chk("idle_addra", addra, 3);

    // Restart from RESET_PC
    start = 1'b1; tick(); start = 1'b0;
    chk("rs0_busy", fetch_busy, 1);
    chk("rs0_addra", addra, 0);
    tick(); tick();
    chk("rs2_valid", instr_valid, 1);
    chk("rs2_pc", instr_pc, 0);
    chk("rs2_instr", instr, 32'h100);
    tick();
    chk("rs3_pc", instr_pc, 1);
    chk("rs3_count", fetch_count, 12);

    // stop and redirect together: stop wins, pc unchanged
    stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h77;
    tick();
    stop = 1'b0; redirect_valid = 1'b0;
    chk("sr_addra", addra, 3);
    chk("sr_busy", fetch_busy, 0);
    chk("sr_valid", instr_valid, 0);
    chk("sr_count", fetch_count, 13);

    // start while fetching is ignored
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("sf2_pc", instr_pc, 0);
    chk("sf2_addra", addra, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("sf3_addra", addra, 3);
    chk("sf3_pc", instr_pc, 1);
    chk("sf3_count", fetch_count, 14);

    // Asynchronous reset between edges
    @(negedge clka);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_addra", addra, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_busy", fetch_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
